doorbell_responder: RTL
=======================

Name: doorbell_responder

Overview:
Consumer-side end of the doorbell protocol. It watches the busy_out levels of NUM_CH doorbell instances and picks a pending channel by round-robin. It hands the selected channel to a single downstream worker through a valid/ready issue handshake, then waits for the worker's completion or a timeout. Finally it returns a one-cycle done pulse to the originating doorbell, which clears that doorbell's busy.

Parameters:
NUM_CH, 4, number of doorbell channels served (1..16)
CH_W, $clog2(NUM_CH) min 1, channel index width (derived, not overridden)
TIMEOUT_CYC, 1024, cycles in WAIT before forced completion; 0 disables timeout
CNT_W, 16, timeout counter width; TIMEOUT_CYC must be < 2**CNT_W

Ports:
clk  input  1  single clock, all logic posedge
rstn  input  1  asynchronous active-low reset
busy_in  input  NUM_CH  per-channel doorbell busy level (from doorbell busy_out)
done_out  output  NUM_CH  one-cycle per-channel done pulse (to doorbell done_in)
job_valid_out  output  1  job offered to worker
job_ch_out  output  CH_W  channel index of offered/active job
job_ready_in  input  1  worker accepts job when high with job_valid_out
job_done_in  input  1  worker completion pulse for active job
timeout_out  output  1  one-cycle pulse when a job is force-completed by timeout
idle_out  output  1  high only in IDLE state

Behaviour:
- Reset (rstn low, async): state=IDLE, done_out=0, job_valid_out=0, job_ch_out=0, timeout_out=0, idle_out=1, rr pointer=0, mask=0, counter=0. Reset mid-job drops the job silently; no done pulse is emitted.
- States: IDLE, ISSUE, WAIT, DONE, HOLD.
- IDLE: eligible = busy_in & ~mask. If eligible != 0, select the first set bit at or after rr pointer (wrapping NUM_CH-1 -> 0), register it to job_ch_out, go to ISSUE. Selection to job_valid_out high takes 1 cycle.
- ISSUE: job_valid_out=1 and job_ch_out held stable. On valid&&ready go to WAIT and clear the counter; job_valid_out is low in WAIT. job_done_in is ignored in ISSUE. The timeout counter does not run in ISSUE.
- WAIT: the counter increments each cycle.
  - On job_done_in: go to DONE.
  - If the counter reaches TIMEOUT_CYC-1 without job_done_in: go to DONE and assert timeout_out in the DONE cycle.
  - If job_done_in arrives in the same cycle as the terminal count: done wins, no timeout_out.
- DONE: done_out[job_ch_out]=1 for exactly one cycle. rr pointer <= job_ch_out+1 (mod NUM_CH). mask <= onehot(job_ch_out). Go to HOLD.
- HOLD: one cycle, because the doorbell clears busy one cycle after sampling done. The masked channel's stale busy must not be re-served. In HOLD, clear mask and go to IDLE.
- A doorbell re-rung later is served normally; its next selection happens at the earliest 2 cycles after the done pulse.
- busy_in deasserting for the active channel during ISSUE/WAIT does not abort the job. The job runs to completion and the done pulse is still sent.
- done_out is at most one-hot. timeout_out is only high in DONE. Every job yields exactly one done pulse.
- Minimum round trip (ready already high, done in the first WAIT cycle): IDLE->ISSUE->WAIT->DONE = done_out 3 cycles after IDLE sees busy. Add 1 HOLD cycle, so the next channel is served at cycle 5.

Decomposition:
- Package doorbell_pkg holds:
  - state enum typedef (IDLE/ISSUE/WAIT/DONE/HOLD)
  - max channel constant
  - doorbell_responder_rr_arb (rotate/find-first helper), shared with any future multi-doorbell logic
- Sub-module rr_arbiter: combinational round-robin find-first over NUM_CH with pointer input, outputs grant index and any_grant.

Test Plan:
- Single channel: busy_in=4'b0010, ready=1, job_done_in 2 cycles into WAIT -> job_ch_out=1, one done_out=4'b0010 pulse, idle_out returns high after HOLD, no timeout_out.
- Round-robin: busy_in=4'b1111 held with each done_out clearing that bit next cycle -> service order 0,1,2,3, each with exactly one done pulse.
- Worker backpressure: job_ready_in low for 7 cycles -> job_valid_out stays high, job_ch_out stable, counter stays 0, WAIT entered on the first ready.
- Timeout: TIMEOUT_CYC=8, job_done_in never asserted -> DONE exactly 8 cycles after entering WAIT, done_out pulse and timeout_out pulse coincide. The same run with job_done_in at the terminal cycle -> timeout_out stays 0.
- Stale busy: channel 2 busy stays high for 1 cycle after done (doorbell model) -> channel 2 is not re-issued. Channel 2 re-rung afterwards -> served again.
- Reset mid-WAIT: rstn low during WAIT on channel 3 -> all outputs go to reset values immediately, no done_out. After release with busy_in[3] still high -> channel 3 is served from the rr pointer reset value 0.

Source files
------------

// File: rtl/doorbell_responder_pkg.sv
// Shared types and the round-robin find-first helper for doorbell consumers.
package doorbell_pkg;

  localparam int MAX_CH   = 16;
  localparam int MAX_CH_W = 4;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, HOLD} state_t;

  typedef struct packed {
    logic                any;
    logic [MAX_CH_W-1:0] idx;
  } rr_grant_t;

  // Scan numCh requests starting at ptr, wrapping, and return the first one set.
  function automatic rr_grant_t doorbell_responder_rr_arb(
    input logic [MAX_CH-1:0]   req,
    input logic [MAX_CH_W-1:0] ptr,
    input int unsigned         numCh
  );
    rr_grant_t           g;
    logic [MAX_CH_W-1:0] idx;
    g = '0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx = MAX_CH_W'((32'(ptr) + k) % numCh);
      if ((k < numCh) && !g.any && req[idx]) begin
        g.any = 1'b1;
        g.idx = idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/doorbell_responder_if.sv
// Job issue/completion handshake between the responder and its single worker.
interface doorbell_responder_if #(
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            job_valid_out;
  logic [CH_W-1:0] job_ch_out;
  logic            job_ready_in;
  logic            job_done_in;

  modport master (
    output job_valid_out,
    output job_ch_out,
    input  job_ready_in,
    input  job_done_in
  );

  modport slave (
    input  job_valid_out,
    input  job_ch_out,
    output job_ready_in,
    output job_done_in
  );
endinterface

// File: rtl/doorbell_responder_rr_arbiter.sv
// Combinational round-robin arbiter: first pending request at or after the pointer.
module rr_arbiter
  import doorbell_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [CH_W-1:0]   o_grant,
  output logic              o_any
);

  rr_grant_t w_grant;

  assign w_grant = doorbell_responder_rr_arb(MAX_CH'(i_req), MAX_CH_W'(i_ptr), NUM_CH);
  assign o_grant = CH_W'(w_grant.idx);
  assign o_any   = w_grant.any;

endmodule

// File: rtl/doorbell_responder.sv
// Picks a busy doorbell by round-robin, issues it to the worker, and pulses done back
// once the worker finishes or the wait times out.
module doorbell_responder
  import doorbell_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NUM_CH-1:0] busy_in,
  output logic [NUM_CH-1:0] done_out,
  output logic              timeout_out,
  output logic              idle_out,
  doorbell_responder_if.master job_if
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYC - 1);

  state_t            r_state;
  logic [CH_W-1:0]   r_ch;
  logic [CH_W-1:0]   r_rrPtr;
  logic [NUM_CH-1:0] r_mask;
  logic [CNT_W-1:0]  r_cnt;
  logic [NUM_CH-1:0] r_done;
  logic              r_timeout;
  logic              r_idle;
  logic              r_valid;

  logic [NUM_CH-1:0] w_eligible;
  logic [CH_W-1:0]   w_grant;
  logic              w_anyGrant;
  logic [NUM_CH-1:0] w_chOnehot;
  logic [CH_W-1:0]   w_nextPtr;
  logic              w_terminal;

  assign w_eligible = busy_in & ~r_mask;
  assign w_chOnehot = NUM_CH'(1) << r_ch;
  assign w_nextPtr  = (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
  assign w_terminal = (TIMEOUT_CYC != 0) && (r_cnt == TERM_CNT);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .i_req   (w_eligible),
    .i_ptr   (r_rrPtr),
    .o_grant (w_grant),
    .o_any   (w_anyGrant)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_rrPtr   <= '0;
      r_mask    <= '0;
      r_cnt     <= '0;
      r_done    <= '0;
      r_timeout <= 1'b0;
      r_idle    <= 1'b1;
      r_valid   <= 1'b0;
    end else begin
      r_done    <= '0;
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyGrant) begin
            r_ch    <= w_grant;
            r_valid <= 1'b1;
            r_idle  <= 1'b0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (job_if.job_ready_in) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        // A completion landing on the terminal count is a normal finish, not a timeout.
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (job_if.job_done_in || w_terminal) begin
            r_done    <= w_chOnehot;
            r_timeout <= !job_if.job_done_in;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_rrPtr <= w_nextPtr;
          r_mask  <= w_chOnehot;
          r_state <= HOLD;
        end
        // The doorbell drops busy a cycle after seeing done; skip that stale level.
        HOLD: begin
          r_mask  <= '0;
          r_idle  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign done_out             = r_done;
  assign timeout_out          = r_timeout;
  assign idle_out             = r_idle;
  assign job_if.job_valid_out = r_valid;
  assign job_if.job_ch_out    = r_ch;

endmodule
